fp_minmax_reduce: RTL and testbench

- Streaming FP32 min/max reducer that sits directly upstream of fp_comp and drives its operand pair (in1/in2, act).
- Consumes its eq/great/less/inv results to maintain a running extreme over a valid/ready input stream terminated by a last flag.
- Emits one result word per stream, plus element count and a sticky invalid flag.
- Used for reductions such as vector max, clamp-range discovery and sort pre-passes.

---
 rtl/fp_minmax_reduce.sv | 177 +++++++++++++++++
 tb/tb_fp_minmax_reduce.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_minmax_reduce.sv
// fp_minmax_reduce
//   Streaming FP32 min/max reducer. It feeds an external fp_comp with the new
//   element (cmp_in1) and the running extreme (cmp_in2). It uses the
//   eq/great/less/inv flags to keep the extreme over a valid/ready stream that
//   ends on in_last. One result is produced per stream.
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     in_valid/in_ready         element handshake
//     in_data, in_last, in_op   element, end-of-stream, 0=min/1=max (first only)
//     cmp_in1/cmp_in2/cmp_act   comparator operands + activate (registered)
//     cmp_eq/great/less/inv     comparator results, valid CMP_LAT cycles after act
//     out_valid/out_ready       result handshake
//     out_data/count/inv        extreme, element count (saturating), sticky invalid
//
//   Optional: define FP_MINMAX_IDX_EN to add out_idx. It is the zero-based
//   stream position of the element held as the extreme.
module fp_minmax_reduce #(
  parameter int W       = 32,
  parameter int CMP_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_last,
  input  logic            in_op,
  output logic [W-1:0]    cmp_in1,
  output logic [W-1:0]    cmp_in2,
  output logic            cmp_act,
  input  logic            cmp_eq,
  input  logic            cmp_great,
  input  logic            cmp_less,
  input  logic            cmp_inv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [CNTW-1:0] out_count,
  output logic            out_inv
`ifdef FP_MINMAX_IDX_EN
  ,
  output logic [CNTW-1:0] out_idx
`endif
);

  localparam logic [1:0] S_FIRST = 2'd0;
  localparam logic [1:0] S_NEXT  = 2'd1;
  localparam logic [1:0] S_CMP   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam int LATW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  logic [1:0]      state;
  logic [W-1:0]    acc, cand;
  logic            op, cand_last, inv_sticky;
  logic [CNTW-1:0] cnt;
  logic [LATW-1:0] lat;
`ifdef FP_MINMAX_IDX_EN
  logic [CNTW-1:0] idx;
`endif

  logic            take_new, inv_nxt, lat_done;
  logic [W-1:0]    acc_nxt;
  logic [CNTW-1:0] cnt_inc;

  // An equal result, an invalid result, or no flag set keeps the current
  // extreme. The element seen first wins on ties.
  always_comb begin
    take_new = !cmp_inv && !cmp_eq && (op ? cmp_great : cmp_less);
    acc_nxt  = take_new ? cand : acc;
    inv_nxt  = inv_sticky | cmp_inv;
    lat_done = (lat == LATW'(CMP_LAT - 1));
    cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FIRST;
      in_ready   <= 1'b0;
      acc        <= '0;
      cand       <= '0;
      op         <= 1'b0;
      cand_last  <= 1'b0;
      inv_sticky <= 1'b0;
      cnt        <= '0;
      lat        <= '0;
      cmp_act    <= 1'b0;
      cmp_in1    <= '0;
      cmp_in2    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_count  <= '0;
      out_inv    <= 1'b0;
`ifdef FP_MINMAX_IDX_EN
      idx        <= '0;
      out_idx    <= '0;
`endif
    end else begin
      case (state)
        S_FIRST: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            acc        <= in_data;
            op         <= in_op;
            cnt        <= CNTW'(1);
            inv_sticky <= 1'b0;
`ifdef FP_MINMAX_IDX_EN
            idx        <= '0;
`endif
            if (in_last) begin
              // A single-element stream skips the comparator entirely.
              state     <= S_OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_count <= CNTW'(1);
              out_inv   <= 1'b0;
`ifdef FP_MINMAX_IDX_EN
              out_idx   <= '0;
`endif
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if (in_valid && in_ready) begin
            cand      <= in_data;
            cand_last <= in_last;
            cnt       <= cnt_inc;
            lat       <= '0;
            in_ready  <= 1'b0;
            cmp_act   <= 1'b1;
            cmp_in1   <= in_data;
            cmp_in2   <= acc;
            state     <= S_CMP;
          end
        end
        S_CMP: begin
          lat <= lat + 1'b1;
          if (lat_done) begin
            acc        <= acc_nxt;
            inv_sticky <= inv_nxt;
            cmp_act    <= 1'b0;
`ifdef FP_MINMAX_IDX_EN
            if (take_new) idx <= cnt - 1'b1;
`endif
            if (cand_last) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_data  <= acc_nxt;
              out_count <= cnt;
              out_inv   <= inv_nxt;
`ifdef FP_MINMAX_IDX_EN
              out_idx   <= take_new ? cnt - 1'b1 : idx;
`endif
            end else begin
              state    <= S_NEXT;
              in_ready <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_FIRST;
          end
        end
        default: state <= S_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Bench for fp_minmax_reduce. It includes a behavioural FP32 comparator on the
// cmp_* interface. Expected results are queued when a stream is driven and
// popped when the result handshake happens.
module tb_fp_minmax_reduce;
  localparam int W = 32, CMP_LAT = 2, CNTW = 4;

  logic clk, rst;
  logic in_valid, in_ready, in_last, in_op;
  logic [W-1:0] in_data, cmp_in1, cmp_in2, out_data;
  logic cmp_act, cmp_eq, cmp_great, cmp_less, cmp_inv;
  logic out_valid, out_ready, out_inv;
  logic [CNTW-1:0] out_count;
`ifdef FP_MINMAX_IDX_EN
  logic [CNTW-1:0] out_idx;
`endif

  fp_minmax_reduce #(.W(W), .CMP_LAT(CMP_LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_op(in_op),
    .cmp_in1(cmp_in1), .cmp_in2(cmp_in2), .cmp_act(cmp_act),
    .cmp_eq(cmp_eq), .cmp_great(cmp_great), .cmp_less(cmp_less), .cmp_inv(cmp_inv),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_inv(out_inv)
`ifdef FP_MINMAX_IDX_EN
    , .out_idx(out_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural comparator. NaN gives inv, +0 and -0 compare equal.
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    if (!a[31]) return a[30:0] < b[30:0];
    return a[30:0] > b[30:0];
  endfunction
  always_comb begin
    cmp_inv = 1'b0; cmp_eq = 1'b0; cmp_great = 1'b0; cmp_less = 1'b0;
    if (cmp_act) begin
      cmp_inv = is_nan(cmp_in1) || is_nan(cmp_in2);
      if (!cmp_inv) begin
        cmp_less  = fp_lt(cmp_in1, cmp_in2);
        cmp_great = fp_lt(cmp_in2, cmp_in1);
        cmp_eq    = !cmp_less && !cmp_great;
      end
    end
  end

  int pass_cnt = 0, total_cnt = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct { logic [31:0] data, cnt, inv, idx; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic op; int n; logic [3:0][31:0] d;
    logic [31:0] data, cnt, inv, idx;
  } vec_t;
  vec_t tbl[7];

  logic [31:0] sd [0:31];
  int pulses = 0, run = 0;
  logic skip_run = 1'b0;
  logic [31:0] h1, h2;
  exp_t e;

  // Result scoreboard plus comparator-operand stability monitor.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_result", 32'(out_valid), 32'd0);
      else begin
        e = sb.pop_front();
        check("out_data", out_data, e.data);
        check("out_count", 32'(out_count), e.cnt);
        check("out_inv", 32'(out_inv), e.inv);
`ifdef FP_MINMAX_IDX_EN
        check("out_idx", 32'(out_idx), e.idx);
`endif
      end
    end
    if (cmp_act) begin
      if (run == 0) begin pulses++; h1 = cmp_in1; h2 = cmp_in2; end
      else begin
        check("cmp_in1_stable", cmp_in1, h1);
        check("cmp_in2_stable", cmp_in2, h2);
      end
      run++;
    end else if (run > 0) begin
      if (skip_run) skip_run = 1'b0;
      else check("cmp_act_len", 32'(run), 32'(CMP_LAT));
      run = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_elem(input logic [31:0] d, input logic last, input logic op);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_op = op;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Later elements carry the inverted op, which the block must ignore.
  task automatic run_stream(input logic op, input int n, input logic [31:0] xd,
                            input logic [31:0] xc, input logic [31:0] xi,
                            input logic [31:0] xx, output int snap);
    exp_t x;
    x.data = xd; x.cnt = xc; x.inv = xi; x.idx = xx;
    sb.push_back(x);
    snap = pulses;
    for (int i = 0; i < n; i++) drive_elem(sd[i], (i == n - 1), (i == 0) ? op : ~op);
  endtask

  task automatic wait_done(input int snap, input int n);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0) check("result_timeout", 32'(sb.size()), 32'd0);
    check("cmp_pulses", 32'(pulses - snap), 32'(n - 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int snap, t;
    tbl[0] = '{1'b1, 3, {32'h0, 32'hC0400000, 32'h40000000, 32'h3F800000}, 32'h40000000, 3, 0, 1};
    tbl[1] = '{1'b0, 3, {32'h0, 32'hC0400000, 32'h40000000, 32'h3F800000}, 32'hC0400000, 3, 0, 2};
    tbl[2] = '{1'b1, 1, {32'h0, 32'h0, 32'h0, 32'h41200000}, 32'h41200000, 1, 0, 0};
    tbl[3] = '{1'b1, 3, {32'h0, 32'h3F000000, 32'h7FC00000, 32'h3F800000}, 32'h3F800000, 3, 1, 0};
    tbl[4] = '{1'b1, 2, {32'h0, 32'h0, 32'h80000000, 32'h00000000}, 32'h00000000, 2, 0, 0};
    tbl[5] = '{1'b0, 4, {32'h3F800000, 32'hBF800000, 32'hBF800000, 32'h40400000}, 32'hBF800000, 4, 0, 1};
    tbl[6] = '{1'b1, 3, {32'h0, 32'hBF800000, 32'hC0400000, 32'hC0000000}, 32'hBF800000, 3, 0, 2};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_op = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cmp_act", 32'(cmp_act), 32'd0);
    check("rst_cmp_in1", cmp_in1, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < tbl[v].n; i++) sd[i] = tbl[v].d[i];
      run_stream(tbl[v].op, tbl[v].n, tbl[v].data, tbl[v].cnt, tbl[v].inv, tbl[v].idx, snap);
      wait_done(snap, tbl[v].n);
    end

    // Single element: result visible right after the accepting edge.
    out_ready = 1'b0;
    sd[0] = 32'h41200000;
    run_stream(1'b0, 1, 32'h41200000, 1, 0, 0, snap);
    check("single_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done(snap, 1);

    // Back-pressure on a tie stream.
    out_ready = 1'b0;
    sd[0] = 32'h00000000; sd[1] = 32'h80000000;
    run_stream(1'b1, 2, 32'h00000000, 2, 0, 0, snap);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check("bp_out_valid_rise", 32'(out_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'h00000000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    wait_done(snap, 2);

    // Counter saturation: 18 rising elements, CNTW=4 saturates at 15.
    for (int i = 0; i < 18; i++) sd[i] = 32'h3F800000 + 32'(i);
    run_stream(1'b1, 18, 32'h3F800011, 15, 0, 14, snap);
    wait_done(snap, 18);

    // Reset while a comparison is in flight.
    drive_elem(32'h40000000, 1'b0, 1'b1);
    drive_elem(32'h3F800000, 1'b0, 1'b1);
    check("abort_in_cmp", 32'(cmp_act), 32'd1);
    skip_run = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_cmp_act", 32'(cmp_act), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_in_ready_after", 32'(in_ready), 32'd1);
    sd[0] = 32'h3F800000; sd[1] = 32'h40000000;
    run_stream(1'b0, 2, 32'h3F800000, 2, 0, 0, snap);
    wait_done(snap, 2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
